// File: rtl/step_dec_pkg.sv
// Shared definitions for the stepping one-hot decoder: state encoding and
// a width-generic one-hot bit helper.
package step_dec_pkg;

    // Decoder state encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // One bit of a one-hot decode: high when enabled and the index hits pos.
    // Taking plain integers keeps it usable for any index width.
    function automatic logic onehot_bit(input int unsigned idx,
                                        input int unsigned pos,
                                        input logic        en);
        return en && (idx == pos);
    endfunction

endpackage

// File: rtl/step_dec_onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable; y[i] is high
// exactly when enable is set and index == i. Generalises the old fixed
// 3-to-8 decoder.
module onehot_dec
    import step_dec_pkg::*;
#(
    parameter int unsigned SEL_W = 3
) (
    input  logic [SEL_W-1:0]     index,
    input  logic                 enable,
    output logic [0:(2**SEL_W)-1] y
);

    localparam int unsigned N = 2 ** SEL_W;

    // One decode term per output position
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign y[i] = onehot_bit(32'(index), 32'(i), enable);
    end

endmodule

// File: rtl/step_dec.sv
// Stepping one-hot decoder. Holds an index and an IDLE/RUN flag; Clear,
// Load and Adv (in that priority, gated by En) move it. Y, Idx and Last
// come straight from flops, so no input reaches Y in the same cycle.
// Build option: STEP_WRAP_EN -- when defined, Adv at the top index wraps
// to 0 and keeps running; otherwise it ends the sequence (back to IDLE).
module step_dec
    import step_dec_pkg::*;
#(
    parameter int unsigned SEL_W = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  En,
    input  logic                  Clear,
    input  logic                  Load,
    input  logic [SEL_W-1:0]      W,
    input  logic                  Adv,
    output logic [0:(2**SEL_W)-1] Y,
    output logic [SEL_W-1:0]      Idx,
    output logic                  Active,
    output logic                  Last
);

    localparam int unsigned N = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N - 1);

    logic [0:0]       state, state_nx;
    logic [SEL_W-1:0] idx, idx_nx;
    logic [0:N-1]     y_q, y_nx;
    logic             last_q, last_nx;

    // State, index and decoded outputs; reset clears everything at once
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            idx    <= '0;
            y_q    <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            y_q    <= y_nx;
            last_q <= last_nx;
        end
    end

    // Command decode: Clear > Load > Adv, all ignored while En is low
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        if (En) begin
            if (Clear) begin
                state_nx = IDLE;
                idx_nx   = '0;
            end else if (Load) begin
                state_nx = RUN;
                idx_nx   = W;
            end else if (Adv) begin
                if (state == IDLE) begin
                    state_nx = RUN;
                    idx_nx   = '0;
                end else if (idx == IDX_MAX) begin
`ifdef STEP_WRAP_EN
                    state_nx = RUN;
`else
                    state_nx = IDLE;
`endif
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + SEL_W'(1);
                end
            end
        end
    end

    // Decode the next state so the registered Y lines up with Idx/Active
    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .index  (idx_nx),
        .enable (state_nx == RUN),
        .y      (y_nx)
    );

    // Last flag tracks the next state as well
    always_comb begin
        last_nx = (state_nx == RUN) && (idx_nx == IDX_MAX);
    end

    assign Y      = y_q;
    assign Idx    = idx;
    assign Active = (state == RUN);
    assign Last   = last_q;

endmodule

// File: doc/step_dec.md
STEP_DEC -- requirements
Module: step_dec

Interface
REQ-001 SHALL have parameter SEL_W, default 3: index width; number of outputs N = 2**SEL_W.
REQ-002 SHALL have port Clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port En, input, 1: global enable; 0 freezes all state.
REQ-005 SHALL have port Clear, input, 1: deactivate the decoder and return the index to 0.
REQ-006 SHALL have port Load, input, 1: load W as the current index and activate.
REQ-007 SHALL have port W, input, SEL_W: index value for Load.
REQ-008 SHALL have port Adv, input, 1: step the index by one.
REQ-009 SHALL have port Y, output, [0:N-1]: registered one-hot; Y[i]=1 exactly when active and index==i.
REQ-010 SHALL have port Idx, output, SEL_W: current index register.
REQ-011 SHALL have port Active, output, 1: state flag; 0 forces Y all-zero.
REQ-012 SHALL have port Last, output, 1: Active and Idx==N-1.

Function
REQ-013 SHALL hold two states (IDLE: Active=0; RUN: Active=1) plus the Idx register; Y derives only from registered state (zero-cycle combinational path from inputs to Y forbidden).
REQ-014 SHALL use command priority Clear > Load > Adv, evaluated only when En=1; with En=0, Idx/Active/Y hold.
REQ-015 Clear SHALL give next Active=0, Idx=0, Y=all zero.
REQ-016 Load SHALL give next Idx=W, Active=1 from either state; Y reflects W one cycle after the Load edge.
REQ-017 Adv in IDLE SHALL give next Idx=0, Active=1 (sequence start).
REQ-018 Adv in RUN with Idx<N-1 SHALL give Idx+1.
REQ-019 Adv in RUN with Idx==N-1 SHALL follow REQ-025/026 (boundary).
REQ-020 No command asserted SHALL hold state.
REQ-021 Y SHALL always be one-hot or all-zero; it is never multi-hot for any input sequence.
REQ-022 Index arithmetic SHALL be unsigned, SEL_W bits, no carry-out beyond the boundary rule.

Reset
REQ-023 Reset=1 SHALL immediately (asynchronously) force Active=0, Idx=0, Y=all zero, Last=0, regardless of Clock/En.
REQ-024 Reset asserted mid-sequence SHALL discard the sequence; after release, the first Adv starts at Idx=0.

Configuration
REQ-025 With STEP_WRAP_EN defined: Adv at Idx==N-1 in RUN SHALL give Idx=0, Active=1 (wrap).
REQ-026 Without STEP_WRAP_EN: Adv at Idx==N-1 in RUN SHALL give Active=0, Idx=0 (sequence end, Y all-zero).

Structure
REQ-027 Shared package step_dec_pkg SHALL hold the state encoding constants (IDLE/RUN) and a width-generic onehot function declaration.
REQ-028 SHALL instantiate one sub-module onehot_dec (parameter SEL_W; inputs index, enable; output [0:N-1] one-hot), the combinational decode generalised from the existing fixed 3-to-8 decoder; step_dec registers its result.

Verification (SEL_W=3)
REQ-029 Reset pulse during RUN at Idx=5 -> Y=8'b00000000, Idx=0, Active=0 before the next Clock edge.
REQ-030 Load W=3'b110, En=1 -> next cycle Y=8'b00000010, Idx=6, Active=1, Last=0.
REQ-031 From IDLE, Adv for 8 cycles -> Y walks 10000000..00000001, Last=1 on the 8th; 9th Adv -> Y=10000000 (STEP_WRAP_EN) or 00000000, Active=0 (no macro).
REQ-032 Clear, Load W=2, Adv all high same cycle -> Active=0, Y=0; Load W=2 with Adv -> Y=00100000.
REQ-033 En=0 with Load W=7 and Adv toggling for 4 cycles -> Y, Idx, Active unchanged.
REQ-034 Random command stream, 1000 cycles, both macro settings -> Y one-hot or zero every cycle, matching a reference model of Idx/Active.
